// File: rtl/r_format_sequencer.sv
// R-format execute sequencer: accepts one instruction, drives register-file/ALU controls, writes back rd.
// Optional retired-instruction counter enabled by defining RFMT_RETIRE_COUNTER_EN.
module r_format_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] rs_address,
    output logic [ADDR_WIDTH-1:0] rt_address,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic [4:0]            shamt,
    output logic [3:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  done,
    output logic                  illegal,
    output logic [31:0]           retired_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_accept;
    logic [4:0]            w_dec;
    logic                  w_legal;
    logic                  r_legal;
    logic [ADDR_WIDTH-1:0] r_rs;
    logic [ADDR_WIDTH-1:0] r_rt;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [4:0]            r_shamt;
    logic [3:0]            r_alu_control;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_write_enable;
    logic                  r_done;
    logic                  r_illegal;

    // Returns {legal, alu_control}; unlisted funct codes come back with legal=0.
    function automatic logic [4:0] decode_funct(input logic [5:0] funct);
        logic [4:0] res;
        case (funct)
            6'h20:   res = 5'b1_0000;
            6'h22:   res = 5'b1_0001;
            6'h24:   res = 5'b1_0010;
            6'h25:   res = 5'b1_0011;
            6'h2A:   res = 5'b1_0100;
            6'h26:   res = 5'b1_0101;
            6'h27:   res = 5'b1_0110;
            6'h00:   res = 5'b1_0111;
            6'h02:   res = 5'b1_1000;
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    assign w_accept = instr_valid && (r_state == IDLE);
    assign w_dec    = decode_funct(instr[5:0]);
    assign w_legal  = (instr[31:26] == 6'd0) && w_dec[4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (instr_valid) w_next_state = DECODE;
            DECODE:    w_next_state = r_legal ? EXECUTE : IDLE;
            EXECUTE:   w_next_state = WRITEBACK;
            WRITEBACK: w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Decode results are registered on the accept edge so they are already valid during DECODE;
    // the illegal pulse is likewise registered there so it lands in the DECODE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_legal        <= 1'b0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_rd           <= '0;
            r_shamt        <= '0;
            r_alu_control  <= '0;
            r_wb_data      <= '0;
            r_write_enable <= 1'b0;
            r_done         <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_write_enable <= 1'b0;
            r_done         <= 1'b0;
            r_illegal      <= 1'b0;
            if (w_accept) begin
                r_legal       <= w_legal;
                r_rs          <= ADDR_WIDTH'(instr[25:21]);
                r_rt          <= ADDR_WIDTH'(instr[20:16]);
                r_rd          <= ADDR_WIDTH'(instr[15:11]);
                r_shamt       <= instr[10:6];
                r_alu_control <= w_dec[3:0];
                if (!w_legal) begin
                    r_done    <= 1'b1;
                    r_illegal <= 1'b1;
                end
            end
            if (r_state == EXECUTE) begin
                r_wb_data      <= alu_result;
                r_done         <= 1'b1;
                r_write_enable <= (r_rd != '0);
            end
        end
    end

`ifdef RFMT_RETIRE_COUNTER_EN
    logic [31:0] r_retired_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired_count <= '0;
        end else if (r_state == WRITEBACK) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign retired_count = r_retired_count;
`else
    assign retired_count = '0;
`endif

    assign instr_ready  = (r_state == IDLE);
    assign rs_address   = r_rs;
    assign rt_address   = r_rt;
    assign rd_address   = r_rd;
    assign shamt        = r_shamt;
    assign alu_control  = r_alu_control;
    assign wb_data      = r_wb_data;
    assign write_enable = r_write_enable;
    assign done         = r_done;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_r_format_sequencer.sv
// Bench for r_format_sequencer: vector table, scoreboard of writebacks, multi-cycle corner sequences.
// Register file is modelled as reg[i] = i so expected ALU results follow from the instruction fields.
module tb_r_format_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs_address;
    logic [4:0]  rt_address;
    logic [4:0]  rd_address;
    logic [4:0]  shamt;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        write_enable;
    logic [31:0] wb_data;
    logic        done;
    logic        illegal;
    logic [31:0] retired_count;

    r_format_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rs_address    (rs_address),
        .rt_address    (rt_address),
        .rd_address    (rd_address),
        .shamt         (shamt),
        .alu_control   (alu_control),
        .alu_result    (alu_result),
        .write_enable  (write_enable),
        .wb_data       (wb_data),
        .done          (done),
        .illegal       (illegal),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [4:0] a_addr, input logic [4:0] b_addr,
                                              input logic [4:0] sh, input logic [3:0] ctrl);
        logic [31:0] a;
        logic [31:0] b;
        a = 32'(a_addr);
        b = 32'(b_addr);
        case (ctrl)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return ~(a | b);
            4'd7:    return b << sh;
            4'd8:    return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_model(rs_address, rt_address, shamt, alu_control);

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [3:0]  ctrl;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        ill;
    } exp_t;

    vec_t        vecs[12];
    exp_t        sb[$];
    int          checks;
    int          failures;
    logic [31:0] exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb_empty actual=done expected=no_pending_entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
            check({tag, "_we"}, 32'(write_enable), 32'(e.we));
            if (!e.ill) begin
                check({tag, "_rd"}, 32'(rd_address), 32'(e.rd));
                check({tag, "_data"}, wb_data, e.data);
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] ins, input logic legal, input logic [31:0] data);
        exp_t e;
        e.rd   = ins[15:11];
        e.data = data;
        e.ill  = !legal;
        e.we   = legal && (ins[15:11] != 5'd0);
        sb.push_back(e);
    endtask

    task automatic check_counter(input string tag);
`ifdef RFMT_RETIRE_COUNTER_EN
        check({tag, "_retired"}, retired_count, exp_count);
`else
        check({tag, "_retired"}, retired_count, 32'd0);
`endif
    endtask

    // Called #1 after an edge with the sequencer idle; returns #1 after the edge it is idle again.
    task automatic run_instr(input vec_t v, input string tag);
        check({tag, "_ready_c0"}, 32'(instr_ready), 32'd1);
        instr       = v.instr;
        instr_valid = 1'b1;
        push_exp(v.instr, v.legal, v.data);
        tick();
        instr_valid = 1'b0;
        instr       = $urandom;
        check({tag, "_ready_c1"}, 32'(instr_ready), 32'd0);
        check({tag, "_rs_c1"}, 32'(rs_address), 32'(v.instr[25:21]));
        check({tag, "_rt_c1"}, 32'(rt_address), 32'(v.instr[20:16]));
        check({tag, "_rdaddr_c1"}, 32'(rd_address), 32'(v.instr[15:11]));
        check({tag, "_shamt_c1"}, 32'(shamt), 32'(v.instr[10:6]));
        check({tag, "_we_c1"}, 32'(write_enable), 32'd0);
        if (!v.legal) begin
            pop_compare({tag, "_c1"});
            tick();
            check({tag, "_ready_c2"}, 32'(instr_ready), 32'd1);
            check({tag, "_done_c2"}, 32'(done), 32'd0);
            check({tag, "_we_c2"}, 32'(write_enable), 32'd0);
        end else begin
            check({tag, "_ctrl_c1"}, 32'(alu_control), 32'(v.ctrl));
            check({tag, "_done_c1"}, 32'(done), 32'd0);
            tick();
            check({tag, "_ready_c2"}, 32'(instr_ready), 32'd0);
            check({tag, "_ctrl_c2"}, 32'(alu_control), 32'(v.ctrl));
            check({tag, "_rs_c2"}, 32'(rs_address), 32'(v.instr[25:21]));
            check({tag, "_done_c2"}, 32'(done), 32'd0);
            check({tag, "_we_c2"}, 32'(write_enable), 32'd0);
            tick();
            check({tag, "_ready_c3"}, 32'(instr_ready), 32'd0);
            pop_compare({tag, "_c3"});
            exp_count = exp_count + 32'd1;
            tick();
            check({tag, "_ready_c4"}, 32'(instr_ready), 32'd1);
            check({tag, "_done_c4"}, 32'(done), 32'd0);
            check({tag, "_we_c4"}, 32'(write_enable), 32'd0);
            check({tag, "_data_hold_c4"}, wb_data, v.data);
        end
        check_counter(tag);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        checks    = 0;
        failures  = 0;
        exp_count = 32'd0;

        vecs[0]  = '{32'h00221820, 1'b1, 4'h0, 32'd3};          // add r3 = r1 + r2
        vecs[1]  = '{32'h00412022, 1'b1, 4'h1, 32'd1};          // sub r4 = r2 - r1
        vecs[2]  = '{32'h00220020, 1'b1, 4'h0, 32'd3};          // add to r0
        vecs[3]  = '{32'h8C220004, 1'b0, 4'h0, 32'd0};          // lw opcode
        vecs[4]  = '{32'h00653024, 1'b1, 4'h2, 32'd1};          // and 3 & 5
        vecs[5]  = '{32'h00653825, 1'b1, 4'h3, 32'd7};          // or
        vecs[6]  = '{32'h0065402A, 1'b1, 4'h4, 32'd1};          // slt 3 < 5
        vecs[7]  = '{32'h00654826, 1'b1, 4'h5, 32'd6};          // xor
        vecs[8]  = '{32'h00655027, 1'b1, 4'h6, 32'hFFFFFFF8};   // nor
        vecs[9]  = '{32'h00055900, 1'b1, 4'h7, 32'h00000050};   // sll 5 << 4
        vecs[10] = '{32'h001F6082, 1'b1, 4'h8, 32'd7};          // srl 31 >> 2
        vecs[11] = '{32'h00221821, 1'b0, 4'h0, 32'd0};          // unlisted funct

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_rs", 32'(rs_address), 32'd0);
        check("rst_rd", 32'(rd_address), 32'd0);
        check("rst_ctrl", 32'(alu_control), 32'd0);
        check("rst_wb", wb_data, 32'd0);
        check("rst_retired", retired_count, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with valid held high; the second word changes while busy and must be ignored.
        a = vecs[0];
        b = '{32'h00853020, 1'b1, 4'h0, 32'd9};
        check("b2b_ready_c0", 32'(instr_ready), 32'd1);
        instr       = a.instr;
        instr_valid = 1'b1;
        push_exp(a.instr, a.legal, a.data);
        tick();
        instr = b.instr;
        check("b2b_ready_c1", 32'(instr_ready), 32'd0);
        check("b2b_rs_c1", 32'(rs_address), 32'd1);
        tick();
        check("b2b_ready_c2", 32'(instr_ready), 32'd0);
        check("b2b_rs_c2", 32'(rs_address), 32'd1);
        tick();
        check("b2b_ready_c3", 32'(instr_ready), 32'd0);
        pop_compare("b2b_first");
        exp_count = exp_count + 32'd1;
        tick();
        check("b2b_ready_c4", 32'(instr_ready), 32'd1);
        push_exp(b.instr, b.legal, b.data);
        tick();
        instr_valid = 1'b0;
        check("b2b_ready_c5", 32'(instr_ready), 32'd0);
        check("b2b_rs_c5", 32'(rs_address), 32'd4);
        check("b2b_rt_c5", 32'(rt_address), 32'd5);
        tick();
        tick();
        pop_compare("b2b_second");
        exp_count = exp_count + 32'd1;
        tick();
        check("b2b_ready_c8", 32'(instr_ready), 32'd1);
        check_counter("b2b");

        // Reset pulled low in the EXECUTE cycle: no write, no done, outputs cleared at once.
        instr       = vecs[1].instr;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        sb.delete();
        exp_count = 32'd0;
        check("mid_rst_ready", 32'(instr_ready), 32'd1);
        check("mid_rst_we", 32'(write_enable), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rs", 32'(rs_address), 32'd0);
        check("mid_rst_rt", 32'(rt_address), 32'd0);
        check("mid_rst_rd", 32'(rd_address), 32'd0);
        check("mid_rst_ctrl", 32'(alu_control), 32'd0);
        check("mid_rst_wb", wb_data, 32'd0);
        check("mid_rst_retired", retired_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_rst_we_hold%0d", i), 32'(write_enable), 32'd0);
            check($sformatf("mid_rst_done_hold%0d", i), 32'(done), 32'd0);
        end
        #1;
        reset = 1'b1;
        run_instr(vecs[0], "post_rst");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
